hps_pll_lock_seq: RTL and testbench
===================================

HPS_PLL_LOCK_SEQ -- requirements
Module: hps_pll_lock_seq

Interface
REQ-001 Parameter RST_CYCLES, default 16: number of cycles pll_rst is held high per reset pulse (≥1).
REQ-002 Parameter STABLE_CYCLES, default 1024: number of consecutive locked cycles required before release (≥1).
REQ-003 Parameter TIMEOUT_CYCLES, default 65536: number of WAIT_LOCK cycles allowed before retry (≥1).
REQ-004 Parameter CNT_W, default 20: shared counter width; it SHALL hold max(RST_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES)-1.
REQ-005 refclk  in  1  sole clock; free-running 50 MHz board reference.
REQ-006 rst_n  in  1  reset; asynchronous and active-low.
REQ-007 pll_locked  in  1  PLL lock indication; asynchronous to refclk.
REQ-008 clear_lost  in  1  synchronous pulse that clears lock_lost.
REQ-009 pll_rst  out  1  active-high reset to the memory PLL.
REQ-010 mem_rst_n  out  1  active-low reset for logic clocked by the PLL outputs.
REQ-011 ready  out  1  high only in state RUN.
REQ-012 lock_lost  out  1  sticky flag; set on loss of lock in RUN.
REQ-013 relock_cnt  out  8  count of lock losses in RUN; saturates at 255.

Function
REQ-014 pll_locked SHALL pass through a 2-flop synchronizer, producing locked_s; all decisions SHALL use locked_s only.
REQ-015 FSM states: RESET_PLL, WAIT_LOCK, STABLE, RUN; one shared counter cnt, cleared on every state transition.
REQ-016 RESET_PLL: pll_rst=1; cnt increments each cycle; at cnt==RST_CYCLES-1 the FSM goes to WAIT_LOCK.
REQ-017 WAIT_LOCK: pll_rst=0; locked_s=1 moves the FSM to STABLE on the next edge.
REQ-018 STABLE: if locked_s=0, the FSM returns to WAIT_LOCK with no flag change; if cnt==STABLE_CYCLES-1 with locked_s=1, it goes to RUN.
REQ-019 RUN: locked_s=0 moves the FSM to RESET_PLL, sets lock_lost and increments relock_cnt (saturating) on the same edge.
REQ-020 All outputs SHALL be registered and change on the same edge as the state transition that causes them.
REQ-021 mem_rst_n and ready SHALL be 1 exactly while the state is RUN; pll_rst SHALL be 1 exactly while the state is RESET_PLL.
REQ-022 clear_lost=1 SHALL clear lock_lost; if a loss occurs in the same cycle, set wins; clear_lost SHALL NOT affect relock_cnt.

Reset
REQ-023 rst_n low SHALL asynchronously force: state RESET_PLL, cnt 0, synchronizer flops 0, pll_rst 1, mem_rst_n 0, ready 0, lock_lost 0, relock_cnt 0.
REQ-024 rst_n assertion mid-operation SHALL drop mem_rst_n without waiting for a refclk edge; the deassertion response is synchronous, and the sequence restarts from RESET_PLL.

Configuration
REQ-025 Macro HPS_PLL_LOCK_TIMEOUT_EN defined: in WAIT_LOCK, cnt==TIMEOUT_CYCLES-1 with locked_s=0 SHALL return the FSM to RESET_PLL (retry); relock_cnt and lock_lost are unchanged.
REQ-026 Macro undefined: WAIT_LOCK waits indefinitely; cnt does not count in WAIT_LOCK; TIMEOUT_CYCLES is unused.

Verification (RST_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32)
REQ-027 Boot: pll_locked=1 throughout, rst_n released -> pll_rst=1 for edges 1-4; ready=mem_rst_n=1 after edge 13; lock_lost=0; relock_cnt=0.
REQ-028 Glitch in STABLE: pll_locked low for 3 cycles at cnt=5 -> FSM returns to WAIT_LOCK; ready is delayed by a full 8-cycle restart; lock_lost stays 0.
REQ-029 Loss in RUN: pll_locked falls -> within 3 edges mem_rst_n=0, ready=0, pll_rst=1 for 4 cycles, lock_lost=1, relock_cnt=1; re-lock restores ready.
REQ-030 Timeout: pll_locked held 0 with macro defined -> pll_rst re-pulses every 36 cycles (4+32); with macro undefined -> pll_rst stays 0 after edge 4 indefinitely.
REQ-031 Async reset in RUN: rst_n low between clock edges -> mem_rst_n=0 and relock_cnt=0 before the next refclk edge.
REQ-032 Saturation and priority: 260 losses -> relock_cnt=255; clear_lost asserted in the same cycle as a loss -> lock_lost=1; clear_lost alone -> lock_lost=0.

Source files
------------

// File: rtl/hps_pll_lock_seq.sv
// Memory-PLL reset/lock sequencer: pulses pll_rst, waits for a stable lock, then releases mem_rst_n.
// Optional WAIT_LOCK timeout/retry is enabled by defining HPS_PLL_LOCK_TIMEOUT_EN.
module hps_pll_lock_seq #(
    parameter int RST_CYCLES     = 16,
    parameter int STABLE_CYCLES  = 1024,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_W          = 20
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       clear_lost,
    output logic       pll_rst,
    output logic       mem_rst_n,
    output logic       ready,
    output logic       lock_lost,
    output logic [7:0] relock_cnt
);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int CNT_MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef HPS_PLL_LOCK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    // The shared counter must reach the largest terminal count.
    if ((64'(CNT_MAX - 1) >> CNT_W) != 64'd0) begin : g_cnt_w_check
        $error("CNT_W too small for the largest cycle count");
    end

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [1:0]       sync_q;
    logic             locked_s;
    logic             pll_rst_q;
    logic             mem_rst_n_q;
    logic             ready_q;
    logic             lock_lost_q;
    logic [7:0]       relock_cnt_q;
    logic [7:0]       relock_cnt_d;

    assign locked_s  = sync_q[1];
    assign cnt_inc_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Saturating increment of the loss counter.
    always_comb begin
        if (relock_cnt_q == 8'd255) begin
            relock_cnt_d = relock_cnt_q;
        end else begin
            relock_cnt_d = relock_cnt_q + 8'd1;
        end
    end

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], pll_locked};
        end
    end

    // Sequencer FSM; outputs are set on the edge that enters the state they belong to.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_PLL;
            cnt_q        <= {CNT_W{1'b0}};
            pll_rst_q    <= 1'b1;
            mem_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            relock_cnt_q <= 8'd0;
        end else begin
            // A loss in RUN below overrides this clear (set wins).
            if (clear_lost) begin
                lock_lost_q <= 1'b0;
            end
            case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= {CNT_W{1'b0}};
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q <= STABLE;
                        cnt_q   <= {CNT_W{1'b0}};
`ifdef HPS_PLL_LOCK_TIMEOUT_EN
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= RESET_PLL;
                        cnt_q     <= {CNT_W{1'b0}};
                        pll_rst_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
`else
                    end else begin
                        cnt_q <= {CNT_W{1'b0}};
                    end
`endif
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= {CNT_W{1'b0}};
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q     <= RUN;
                        cnt_q       <= {CNT_W{1'b0}};
                        mem_rst_n_q <= 1'b1;
                        ready_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_inc_s;
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_q      <= RESET_PLL;
                        cnt_q        <= {CNT_W{1'b0}};
                        pll_rst_q    <= 1'b1;
                        mem_rst_n_q  <= 1'b0;
                        ready_q      <= 1'b0;
                        lock_lost_q  <= 1'b1;
                        relock_cnt_q <= relock_cnt_d;
                    end else begin
                        cnt_q <= {CNT_W{1'b0}};
                    end
                end
                default: begin
                    state_q     <= RESET_PLL;
                    cnt_q       <= {CNT_W{1'b0}};
                    pll_rst_q   <= 1'b1;
                    mem_rst_n_q <= 1'b0;
                    ready_q     <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst    = pll_rst_q;
    assign mem_rst_n  = mem_rst_n_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign relock_cnt = relock_cnt_q;

endmodule

// File: tb/tb_hps_pll_lock_seq.sv
// Scoreboard bench for hps_pll_lock_seq: stimulus queues hand-computed expectations tagged with
// the refclk edge after which they hold; a monitor pops and compares them on the falling edge.
module tb_hps_pll_lock_seq;

    localparam logic [11:0] M_ALL = 12'hFFF;
    localparam logic [11:0] M_CTL = 12'hE00;

    typedef struct {
        int          at;
        string       name;
        logic [11:0] exp;
        logic [11:0] mask;
    } sb_ent_t;

    logic       refclk;
    logic       rst_n;
    logic       pll_locked;
    logic       clear_lost;
    logic       pll_rst;
    logic       mem_rst_n;
    logic       ready;
    logic       lock_lost;
    logic [7:0] relock_cnt;
    logic [11:0] obs;

    int      edge_cnt = 0;
    int      n_checks = 0;
    int      n_fail   = 0;
    sb_ent_t sb[$];
    sb_ent_t mon_e;

    hps_pll_lock_seq #(
        .RST_CYCLES    (4),
        .STABLE_CYCLES (8),
        .TIMEOUT_CYCLES(32),
        .CNT_W         (20)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .clear_lost(clear_lost),
        .pll_rst   (pll_rst),
        .mem_rst_n (mem_rst_n),
        .ready     (ready),
        .lock_lost (lock_lost),
        .relock_cnt(relock_cnt)
    );

    assign obs = {pll_rst, mem_rst_n, ready, lock_lost, relock_cnt};

    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    always @(posedge refclk) edge_cnt = edge_cnt + 1;

    // Monitor: compare every expectation due after the edge just taken.
    always @(negedge refclk) begin
        while (sb.size() > 0 && sb[0].at <= edge_cnt) begin
            mon_e = sb.pop_front();
            n_checks++;
            if (mon_e.at != edge_cnt || (obs & mon_e.mask) !== (mon_e.exp & mon_e.mask)) begin
                n_fail++;
                $display("FAIL %s @edge %0d: got {rst,mrn,rdy,lost,cnt}=%b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d mask %h",
                         mon_e.name, edge_cnt, obs[11], obs[10], obs[9], obs[8], obs[7:0],
                         mon_e.exp[11], mon_e.exp[10], mon_e.exp[9], mon_e.exp[8], mon_e.exp[7:0], mon_e.mask);
            end
        end
    end

    task automatic exp_at(input int rel, input string nm, input logic pr, input logic mr,
                          input logic rd, input logic ll, input logic [7:0] rc, input logic [11:0] mask);
        sb_ent_t e;
        int idx;
        e.at   = edge_cnt + rel;
        e.name = nm;
        e.exp  = {pr, mr, rd, ll, rc};
        e.mask = mask;
        idx = sb.size();
        while (idx > 0 && sb[idx-1].at > e.at) idx--;
        sb.insert(idx, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge refclk);
        #1;
    endtask

    // One loss-and-relock round from RUN; optional clear_lost collides with the loss edge.
    task automatic loss_cycle(input int n, input bit pri);
        logic [7:0] rc;
        rc = (n > 255) ? 8'd255 : 8'(n);
        if (pri) begin
            clear_lost = 1'b1;
            exp_at(1, "pri_pre_clear", 1'b0, 1'b1, 1'b1, 1'b0, 8'd255, M_ALL);
            tick(1);
            clear_lost = 1'b0;
        end
        pll_locked = 1'b0;
        exp_at(3, pri ? "pri_set_wins" : "sat_loss", 1'b1, 1'b0, 1'b0, 1'b1, rc, M_ALL);
        exp_at(16, "sat_relock", 1'b0, 1'b1, 1'b1, 1'b1, rc, M_ALL);
        tick(2);
        if (pri) clear_lost = 1'b1;
        tick(1);
        clear_lost = 1'b0;
        pll_locked = 1'b1;
        tick(13);
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b1;
        clear_lost = 1'b0;
        tick(3);
        exp_at(1, "reset_state", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL);
        tick(2);

        // Boot with lock present throughout
        rst_n = 1'b1;
        exp_at(1,  "boot_e1",  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL);
        exp_at(3,  "boot_e3",  1'b1, 1'b0, 1'b0, 1'b0, 8'd0, M_CTL);
        exp_at(4,  "boot_e4",  1'b0, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL);
        exp_at(12, "boot_e12", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL);
        exp_at(13, "boot_run", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, M_ALL);
        tick(16);

        // Loss in RUN, relock
        pll_locked = 1'b0;
        exp_at(2,  "loss_e2",      1'b0, 1'b1, 1'b1, 1'b0, 8'd0, M_ALL);
        exp_at(3,  "loss_e3",      1'b1, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(6,  "loss_rst_hold",1'b1, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(7,  "loss_rst_end", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(15, "relock_pre",   1'b0, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(16, "relock_run",   1'b0, 1'b1, 1'b1, 1'b1, 8'd1, M_ALL);
        tick(5);
        pll_locked = 1'b1;
        tick(14);

        // clear_lost alone
        clear_lost = 1'b1;
        exp_at(1, "clear_alone", 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, M_ALL);
        tick(1);
        clear_lost = 1'b0;
        tick(2);

        // Asynchronous reset mid-cycle in RUN
        @(posedge refclk);
        #2;
        rst_n = 1'b0;
        exp_at(0, "async_rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL);
        tick(3);

        // Three-cycle glitch while STABLE cnt=5
        rst_n = 1'b1;
        exp_at(10, "glitch_cnt5", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL);
        tick(10);
        pll_locked = 1'b0;
        exp_at(3,  "glitch_no_run", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL);
        exp_at(13, "glitch_pre",    1'b0, 1'b0, 1'b0, 1'b0, 8'd0, M_ALL);
        exp_at(14, "glitch_run",    1'b0, 1'b1, 1'b1, 1'b0, 8'd0, M_ALL);
        tick(3);
        pll_locked = 1'b1;
        tick(12);

        // Lock held low: retry pulses only with the timeout build
        pll_locked = 1'b0;
        exp_at(3, "to_loss", 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(7, "to_wait", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
`ifdef HPS_PLL_LOCK_TIMEOUT_EN
        exp_at(38, "to_wait_end",   1'b0, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(39, "to_retry",      1'b1, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(42, "to_retry_hold", 1'b1, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(43, "to_retry_end",  1'b0, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(75, "to_retry2",     1'b1, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
`else
        exp_at(39,  "no_to_39",  1'b0, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(75,  "no_to_75",  1'b0, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
        exp_at(120, "no_to_120", 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, M_ALL);
`endif
        tick(125);

        // Fresh boot, then 260 losses for saturation and set-over-clear priority
        rst_n = 1'b0;
        pll_locked = 1'b1;
        tick(2);
        rst_n = 1'b1;
        exp_at(13, "sat_boot", 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, M_ALL);
        tick(16);
        for (int i = 1; i <= 260; i++) begin
            loss_cycle(i, i == 260);
        end
        clear_lost = 1'b1;
        exp_at(1, "sat_clear", 1'b0, 1'b1, 1'b1, 1'b0, 8'd255, M_ALL);
        tick(1);
        clear_lost = 1'b0;

        for (int k = 0; k < 50 && sb.size() > 0; k++) tick(1);
        if (sb.size() != 0) begin
            $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
            n_fail += sb.size();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
